stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data and return-address width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of stack entries (power of 2, >=2).
REQ-003 SHALL have parameter CW, default $clog2(DEPTH+1), meaning occupancy counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port push  input  1  push din this cycle.
REQ-007 SHALL have port pop  input  1  discard top entry this cycle.
REQ-008 SHALL have port call  input  1  push return address pc_in+1.
REQ-009 SHALL have port ret  input  1  pop top entry to ret_pc.
REQ-010 SHALL have port din  input  DW  data to push.
REQ-011 SHALL have port pc_in  input  DW  current program counter.
REQ-012 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-013 SHALL have port top  output  DW  registered top-of-stack value.
REQ-014 SHALL have port ret_pc  output  DW  return address popped by ret.
REQ-015 SHALL have port ret_valid  output  1  one-cycle strobe, ret_pc valid.
REQ-016 SHALL have port lnk  output  DW  link register, last call return address.
REQ-017 SHALL have port count  output  CW  current occupancy 0..DEPTH.
REQ-018 SHALL have ports full and empty  output  1 each  count==DEPTH / count==0.
REQ-019 SHALL have ports ovf and udf  output  1 each  sticky overflow / underflow flags.
REQ-020 SHALL have port trap  output  1  error-event pulse (see Configuration).

Function
REQ-021 SHALL use a single unified LIFO for data and return addresses, storage DEPTH x DW, stack pointer plus CW-bit counter.
REQ-022 SHALL apply command priority call > ret > (push/pop); lower-priority commands in the same cycle are ignored, no error raised for them.
REQ-023 SHALL complete every command in one cycle; top, count, full, empty, lnk reflect the command on the next rising edge.
REQ-024 SHALL on call (not full) store pc_in+1 modulo 2^DW, increment count, load lnk with the same value.
REQ-025 SHALL on ret (not empty) drive ret_pc with the top entry, pulse ret_valid high for exactly one cycle, decrement count.
REQ-026 SHALL on push alone (not full) store din, increment count; on pop alone (not empty) decrement count.
REQ-027 SHALL on push and pop together replace the top entry with din, count unchanged; when empty treat as plain push.
REQ-028 SHALL on push or call while full ignore the write, keep all state, and set ovf.
REQ-029 SHALL on pop or ret while empty keep all state, keep ret_valid low, and set udf.
REQ-030 SHALL drive top as 0 whenever empty, otherwise the most recent entry.
REQ-031 SHALL clear ovf and udf on clr_err; a same-cycle new error event wins and sets the flag.
REQ-032 SHALL never wrap the counter; occupancy saturates at 0 and DEPTH.

Reset
REQ-033 SHALL on rst low, asynchronously, set count 0, pointer 0, top 0, ret_pc 0, ret_valid 0, lnk 0, ovf 0, udf 0, trap 0, empty 1, full 0.
REQ-034 SHALL abandon any command in progress at reset; storage contents need not be cleared.
REQ-035 SHALL release reset synchronously to the first clk edge with rst high; no command is taken on that edge unless rst was high before it.

Configuration
REQ-036 SHALL with STACK_TRAP_EN defined drive trap high for exactly one cycle following any overflow or underflow event, independent of the sticky flags.
REQ-037 SHALL without STACK_TRAP_EN keep the trap port present and tied to 0; ovf/udf behaviour unchanged.

Verification (DW=8, DEPTH=4)
REQ-038 SHALL cover: push 0x11,0x22,0x33,0x44 -> count 4, full 1, top 0x44; extra push 0x55 -> top 0x44, ovf 1.
REQ-039 SHALL cover: call with pc_in 0xFF on empty stack -> lnk 0x00, top 0x00, count 1; ret -> ret_pc 0x00, ret_valid 1 cycle, empty 1.
REQ-040 SHALL cover: pop on empty -> udf 1, count 0, ret_valid 0; clr_err -> udf 0; trap pulses 1 cycle only with STACK_TRAP_EN.
REQ-041 SHALL cover: push 0x10 then push+pop with din 0x20 -> top 0x20, count 1.
REQ-042 SHALL cover: call and push same cycle, pc_in 0x40, din 0x99 -> top 0x41, count 1, din discarded.
REQ-043 SHALL cover: rst low mid-sequence with count 3 -> immediately count 0, empty 1, lnk 0, flags 0 without a clk edge.

Source files
------------

// File: rtl/stack_unit.sv
// Unified data/return-address LIFO with call/ret support, sticky ovf/udf flags; optional trap pulse under STACK_TRAP_EN.
// Latency: every command completes in one cycle; all outputs are registered or decoded from registered state.
// Backpressure: none; push/call while full and pop/ret while empty are dropped and flagged instead of stalled.
module stack_unit #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          call,
    input  logic          ret,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] pc_in,
    input  logic          clr_err,
    output logic [DW-1:0] top,
    output logic [DW-1:0] ret_pc,
    output logic          ret_valid,
    output logic [DW-1:0] lnk,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf,
    output logic          trap
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] sp_q, sp_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [DW-1:0] top_q, top_n;
    logic [DW-1:0] ret_pc_q, ret_pc_n;
    logic          ret_vld_q, ret_vld_n;
    logic [DW-1:0] lnk_q, lnk_n;
    logic          ovf_q, ovf_n;
    logic          udf_q, udf_n;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_dat;
    logic          ovf_evt;
    logic          udf_evt;

    logic          is_full;
    logic          is_empty;
    logic [DW-1:0] ret_addr;
    logic [DW-1:0] below_top;

    assign is_full   = (cnt_q == CW'(DEPTH));
    assign is_empty  = (cnt_q == '0);
    assign ret_addr  = pc_in + DW'(1);
    // sp_q is the next free slot, so the entry exposed by a pop sits two below it.
    assign below_top = mem[sp_q - AW'(2)];

    always_comb begin
        sp_n      = sp_q;
        cnt_n     = cnt_q;
        top_n     = top_q;
        ret_pc_n  = ret_pc_q;
        ret_vld_n = 1'b0;
        lnk_n     = lnk_q;
        wr_en     = 1'b0;
        wr_idx    = sp_q;
        wr_dat    = din;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;

        if (call) begin
            if (is_full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_dat = ret_addr;
                sp_n   = sp_q + AW'(1);
                cnt_n  = cnt_q + CW'(1);
                top_n  = ret_addr;
                lnk_n  = ret_addr;
            end
        end else if (ret) begin
            if (is_empty) begin
                udf_evt = 1'b1;
            end else begin
                ret_pc_n  = top_q;
                ret_vld_n = 1'b1;
                sp_n      = sp_q - AW'(1);
                cnt_n     = cnt_q - CW'(1);
                top_n     = (cnt_q == CW'(1)) ? '0 : below_top;
            end
        end else if (push && pop && !is_empty) begin
            // Replace in place: occupancy is unchanged, so this never overflows.
            wr_en  = 1'b1;
            wr_idx = sp_q - AW'(1);
            top_n  = din;
        end else if (push) begin
            if (is_full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en = 1'b1;
                sp_n  = sp_q + AW'(1);
                cnt_n = cnt_q + CW'(1);
                top_n = din;
            end
        end else if (pop) begin
            if (is_empty) begin
                udf_evt = 1'b1;
            end else begin
                sp_n  = sp_q - AW'(1);
                cnt_n = cnt_q - CW'(1);
                top_n = (cnt_q == CW'(1)) ? '0 : below_top;
            end
        end

        // A new error in the same cycle as clr_err leaves the flag set.
        ovf_n = ovf_evt | (ovf_q & ~clr_err);
        udf_n = udf_evt | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q      <= '0;
            cnt_q     <= '0;
            top_q     <= '0;
            ret_pc_q  <= '0;
            ret_vld_q <= 1'b0;
            lnk_q     <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            sp_q      <= sp_n;
            cnt_q     <= cnt_n;
            top_q     <= top_n;
            ret_pc_q  <= ret_pc_n;
            ret_vld_q <= ret_vld_n;
            lnk_q     <= lnk_n;
            ovf_q     <= ovf_n;
            udf_q     <= udf_n;
        end
    end

    // Storage is not reset; writes are gated so an edge during reset leaves it alone.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            mem[wr_idx] <= wr_dat;
        end
    end

`ifdef STACK_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= ovf_evt | udf_evt;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign top       = top_q;
    assign ret_pc    = ret_pc_q;
    assign ret_valid = ret_vld_q;
    assign lnk       = lnk_q;
    assign count     = cnt_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (DW=8, DEPTH=4): queue-based reference model checked every cycle, plus literal checkpoints.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, call, ret, clr_err;
    logic [7:0] din, pc_in;
    logic [7:0] top, ret_pc, lnk;
    logic       ret_valid, full, empty, ovf, udf, trap;
    logic [2:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    stack_unit #(.DW(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .call(call), .ret(ret),
        .din(din), .pc_in(pc_in), .clr_err(clr_err),
        .top(top), .ret_pc(ret_pc), .ret_valid(ret_valid), .lnk(lnk),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf), .trap(trap)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue whose back is the top of stack.
    logic [7:0] mq[$];
    logic [7:0] m_lnk, m_ret_pc;
    logic       m_ret_vld, m_ovf, m_udf, m_trap;
    bit         m_eo, m_eu;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_lnk = 0; m_ret_pc = 0; m_ret_vld = 0;
            m_ovf = 0; m_udf = 0; m_trap = 0;
        end else begin
            m_eo = 0; m_eu = 0; m_ret_vld = 0;
            if (call) begin
                if (mq.size() == 4) m_eo = 1;
                else begin m_lnk = pc_in + 8'd1; mq.push_back(m_lnk); end
            end else if (ret) begin
                if (mq.size() == 0) m_eu = 1;
                else begin m_ret_pc = mq.pop_back(); m_ret_vld = 1; end
            end else if (push && pop) begin
                if (mq.size() == 0) mq.push_back(din);
                else mq[mq.size()-1] = din;
            end else if (push) begin
                if (mq.size() == 4) m_eo = 1;
                else mq.push_back(din);
            end else if (pop) begin
                if (mq.size() == 0) m_eu = 1;
                else void'(mq.pop_back());
            end
            if (clr_err) begin m_ovf = 0; m_udf = 0; end
            if (m_eo) m_ovf = 1;
            if (m_eu) m_udf = 1;
`ifdef STACK_TRAP_EN
            m_trap = m_eo | m_eu;
`else
            m_trap = 0;
`endif
        end
    end

    function automatic logic [7:0] m_top();
        return (mq.size() == 0) ? 8'h00 : mq[mq.size()-1];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("top",       top,       m_top());
            chk("count",     count,     32'(mq.size()));
            chk("full",      full,      mq.size() == 4);
            chk("empty",     empty,     mq.size() == 0);
            chk("lnk",       lnk,       m_lnk);
            chk("ret_pc",    ret_pc,    m_ret_pc);
            chk("ret_valid", ret_valid, m_ret_vld);
            chk("ovf",       ovf,       m_ovf);
            chk("udf",       udf,       m_udf);
            chk("trap",      trap,      m_trap);
        end
    end

    task automatic cyc(input logic pu, input logic po, input logic ca, input logic re,
                       input logic [7:0] d, input logic [7:0] pc, input logic cl);
        push = pu; pop = po; call = ca; ret = re; din = d; pc_in = pc; clr_err = cl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; push = 0; pop = 0; call = 0; ret = 0; clr_err = 0; din = 0; pc_in = 0;
        #2;
        chk("rst_count", count, 0);   chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        chk("rst_top", top, 0);       chk("rst_lnk", lnk, 0);     chk("rst_ret_pc", ret_pc, 0);
        chk("rst_ret_valid", ret_valid, 0); chk("rst_ovf", ovf, 0); chk("rst_udf", udf, 0);
        chk("rst_trap", trap, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        idle();

        // Fill, then overflow.
        cyc(1, 0, 0, 0, 8'h11, 0, 0); cyc(1, 0, 0, 0, 8'h22, 0, 0);
        cyc(1, 0, 0, 0, 8'h33, 0, 0); cyc(1, 0, 0, 0, 8'h44, 0, 0);
        chk("fill_count", count, 4); chk("fill_full", full, 1); chk("fill_top", top, 8'h44);
        cyc(1, 0, 0, 0, 8'h55, 0, 0);
        chk("ovf_top", top, 8'h44); chk("ovf_flag", ovf, 1); chk("ovf_count", count, 4);
`ifdef STACK_TRAP_EN
        chk("ovf_trap", trap, 1);
`else
        chk("ovf_trap", trap, 0);
`endif
        idle();
        chk("ovf_trap_drop", trap, 0); chk("ovf_sticky", ovf, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("ovf_clr", ovf, 0);
        cyc(1, 1, 0, 0, 8'h66, 0, 0);
        chk("repl_full_top", top, 8'h66); chk("repl_full_ovf", ovf, 0);

        // Drain, then underflow.
        repeat (4) cyc(0, 1, 0, 0, 0, 0, 0);
        chk("drain_empty", empty, 1); chk("drain_top", top, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("udf_flag", udf, 1); chk("udf_count", count, 0); chk("udf_ret_valid", ret_valid, 0);
`ifdef STACK_TRAP_EN
        chk("udf_trap", trap, 1);
`else
        chk("udf_trap", trap, 0);
`endif
        idle();
        chk("udf_trap_drop", trap, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("udf_clr", udf, 0);

        // Call with PC wrap, then return.
        cyc(0, 0, 1, 0, 0, 8'hFF, 0);
        chk("call_lnk", lnk, 8'h00); chk("call_top", top, 8'h00); chk("call_count", count, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("ret_pc", ret_pc, 8'h00); chk("ret_vld", ret_valid, 1); chk("ret_empty", empty, 1);
        idle();
        chk("ret_vld_drop", ret_valid, 0);

        // Replace top, and push+pop on empty.
        cyc(1, 0, 0, 0, 8'h10, 0, 0);
        cyc(1, 1, 0, 0, 8'h20, 0, 0);
        chk("repl_top", top, 8'h20); chk("repl_count", count, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8'h77, 0, 0);
        chk("pp_empty_top", top, 8'h77); chk("pp_empty_count", count, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Priority: call beats push, ret beats push.
        cyc(1, 0, 1, 0, 8'h99, 8'h40, 0);
        chk("prio_top", top, 8'h41); chk("prio_count", count, 1); chk("prio_lnk", lnk, 8'h41);
        cyc(1, 0, 0, 0, 8'h05, 0, 0);
        cyc(1, 0, 0, 1, 8'h07, 0, 0);
        chk("prio_ret_pc", ret_pc, 8'h05); chk("prio_ret_count", count, 1); chk("prio_ret_top", top, 8'h41);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("ret2_pc", ret_pc, 8'h41); chk("ret2_empty", empty, 1);

        // Clear and new error in the same cycle: error wins.
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("clr_vs_err", udf, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("clr_udf", udf, 0);

        // Fill with calls, then overflow by call.
        cyc(0, 0, 1, 0, 0, 8'h10, 0); cyc(0, 0, 1, 0, 0, 8'h20, 0);
        cyc(0, 0, 1, 0, 0, 8'h30, 0); cyc(0, 0, 1, 0, 0, 8'h40, 0);
        chk("callfill_top", top, 8'h41); chk("callfill_full", full, 1);
        cyc(0, 0, 1, 0, 0, 8'h50, 0);
        chk("callovf_flag", ovf, 1); chk("callovf_lnk", lnk, 8'h41);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("pre_rst_count", count, 3); chk("pre_rst_top", top, 8'h31);

        // Asynchronous reset mid-cycle, with a push held across it.
        push = 1; pop = 0; call = 0; ret = 0; clr_err = 0; din = 8'hAB; pc_in = 0;
        #2 rst = 0;
        #1;
        chk("arst_count", count, 0); chk("arst_empty", empty, 1); chk("arst_lnk", lnk, 0);
        chk("arst_ovf", ovf, 0);     chk("arst_udf", udf, 0);     chk("arst_top", top, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_count", count, 0);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_count", count, 1); chk("post_rst_top", top, 8'hAB);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
